// File: rtl/move_pkg.sv
// Shared types and default widths for the move sequencer.
package move_pkg;

    localparam int unsigned PERIOD_W_DEF   = 32;
    localparam int unsigned COUNT_W_DEF    = 16;
    localparam int unsigned MIN_PERIOD_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/move_sequencer_if.sv
// Command handshake and status bundle between a controller and the sequencer.
interface move_sequencer_if
    import move_pkg::*;
#(
    parameter int unsigned PERIOD_W = PERIOD_W_DEF,
    parameter int unsigned COUNT_W  = COUNT_W_DEF
) ();

    logic                cmd_valid;
    logic                cmd_ready;
    logic [PERIOD_W-1:0] cmd_period;
    logic [COUNT_W-1:0]  cmd_steps;
    logic                cmd_dir;
    logic                abort;
    logic                step_out;
    logic                dir_out;
    logic                busy;
    logic                done;
    logic                aborted;
    logic                err;
    logic [COUNT_W-1:0]  steps_left;

    modport master (
        output cmd_valid, cmd_period, cmd_steps, cmd_dir, abort,
        input  cmd_ready, step_out, dir_out, busy, done, aborted, err, steps_left
    );

    modport slave (
        input  cmd_valid, cmd_period, cmd_steps, cmd_dir, abort,
        output cmd_ready, step_out, dir_out, busy, done, aborted, err, steps_left
    );

endinterface

// File: rtl/tick_gen.sv
// Step-period divider: counts 0..period-1 while enabled, tick marks the wrap cycle.
module tick_gen
    import move_pkg::*;
#(
    parameter int unsigned PERIOD_W = PERIOD_W_DEF
) (
    input  logic                clk_in,
    input  logic                reset_n,
    input  logic                load_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic                clear_i,
    input  logic                en_i,
    output logic                tick_o
);

    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] count_q, count_d;
    logic                tick_q, tick_d;

    // Next period/count; tick is precomputed so it is a flop aligned with count_q.
    always_comb begin
        period_d = period_q;
        count_d  = count_q;
        if (load_i) begin
            period_d = period_i;
        end
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = tick_q ? '0 : count_q + PERIOD_W'(1);
        end
        tick_d = (count_d == period_d - PERIOD_W'(1));
    end

    // Counter state.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            period_q <= '0;
            count_q  <= '0;
            tick_q   <= 1'b0;
        end else begin
            period_q <= period_d;
            count_q  <= count_d;
            tick_q   <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/move_sequencer.sv
// Stepper move sequencer: accepts a move command and issues timed step pulses.
module move_sequencer
    import move_pkg::*;
#(
    parameter int unsigned PERIOD_W   = PERIOD_W_DEF,
    parameter int unsigned COUNT_W    = COUNT_W_DEF,
    parameter int unsigned MIN_PERIOD = MIN_PERIOD_DEF
) (
    input  logic            clk_in,
    input  logic            reset_n,
    move_sequencer_if.slave bus
);

    state_e               state_q, state_d;
    logic                 dir_q, dir_d;
    logic [COUNT_W-1:0]   steps_q, steps_d;
    logic                 done_q, done_d;
    logic                 aborted_q, aborted_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;

    logic                 accept;
    logic                 tick;
    logic                 tg_load;
    logic                 tg_clear;
    logic                 tg_en;
    logic                 step_c;

    assign accept = bus.cmd_valid & ready_q;

    tick_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_tick_gen (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .load_i   (tg_load),
        .period_i (bus.cmd_period),
        .clear_i  (tg_clear),
        .en_i     (tg_en),
        .tick_o   (tick)
    );

    // Next-state, pulse and counter-control decode.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        steps_d   = steps_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        err_d     = 1'b0;
        tg_load   = 1'b0;
        tg_clear  = 1'b0;
        tg_en     = 1'b0;
        step_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tg_load  = 1'b1;
                    tg_clear = 1'b1;
                    if (bus.cmd_period < PERIOD_W'(MIN_PERIOD)) begin
                        err_d = 1'b1;
                    end else if (bus.cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                        dir_d   = bus.cmd_dir;
                        steps_d = bus.cmd_steps;
                    end
                end
            end
            ST_SETUP: begin
                if (bus.abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort beats a coincident tick: no pulse, no decrement.
                if (bus.abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    tg_en = 1'b1;
                    if (tick) begin
                        step_c  = 1'b1;
                        steps_d = steps_q - COUNT_W'(1);
                        if (steps_q == COUNT_W'(1)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d == ST_SETUP) || (state_d == ST_RUN);
        ready_d = (state_d == ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            dir_q     <= 1'b0;
            steps_q   <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            steps_q   <= steps_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.cmd_ready  = ready_q;
    assign bus.step_out   = step_c;
    assign bus.dir_out    = dir_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.aborted    = aborted_q;
    assign bus.err        = err_q;
    assign bus.steps_left = steps_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: cycle-level reference model, vector table, directed timing cases.
module tb_move_sequencer;
    import move_pkg::*;

    localparam int unsigned PW   = 32;
    localparam int unsigned CW   = 16;
    localparam int unsigned MINP = 2;

    logic clk_in = 1'b0;
    logic reset_n;
    always #5 clk_in = ~clk_in;

    move_sequencer_if #(.PERIOD_W(PW), .COUNT_W(CW)) bus ();

    move_sequencer #(
        .PERIOD_W   (PW),
        .COUNT_W    (CW),
        .MIN_PERIOD (MINP)
    ) dut (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: a move is described by its start cycle offset (rel),
    // period and step count; every output follows by arithmetic on rel.
    bit          m_on, m_done_st;
    int unsigned m_rel, m_p, m_s;
    logic        m_dir;
    logic [CW-1:0] m_sl;
    bit          p_done, p_abort, p_err, p_ready;

    // Last observed outputs.
    logic o_step, o_done, o_ready, o_busy, o_err, o_aborted, o_dir;
    logic [CW-1:0] o_sl;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    endtask

    function automatic int unsigned taken(input int unsigned rel, input int unsigned p);
        return (rel == 0) ? 0 : (rel - 1) / p;
    endfunction

    // One clock cycle: drive, check at the falling edge, advance the model at the rising edge.
    task automatic cycle(input bit v, input logic [PW-1:0] per, input logic [CW-1:0] st,
                         input logic d, input bit ab);
        logic [22:0] exp_v, act_v;
        logic        e_step;
        logic [CW-1:0] e_sl;
        bit n_done, n_abort, n_err;
        cyc++;
        bus.cmd_valid  = v;
        bus.cmd_period = per;
        bus.cmd_steps  = st;
        bus.cmd_dir    = d;
        bus.abort      = ab;
        @(negedge clk_in);
        e_step = m_on && (m_rel > 0) && ((m_rel % m_p) == 0) && !ab;
        e_sl   = m_on ? CW'(m_s - taken(m_rel, m_p)) : m_sl;
        exp_v  = {p_ready, m_on, p_done, p_abort, p_err, e_step, m_dir, e_sl};
        act_v  = {bus.cmd_ready, bus.busy, bus.done, bus.aborted, bus.err,
                  bus.step_out, bus.dir_out, bus.steps_left};
        check("outputs{rdy,busy,done,abt,err,step,dir,left}", 64'(act_v), 64'(exp_v));
        o_step = bus.step_out; o_done = bus.done; o_ready = bus.cmd_ready;
        o_busy = bus.busy; o_err = bus.err; o_aborted = bus.aborted;
        o_dir = bus.dir_out; o_sl = bus.steps_left;
        @(posedge clk_in);
        n_done = 0; n_abort = 0; n_err = 0;
        if (m_on) begin
            if (ab) begin
                m_sl = CW'(m_s - taken(m_rel, m_p));
                m_on = 0;
                n_abort = 1;
            end else if (m_rel == m_p * m_s) begin
                m_on = 0;
                m_sl = '0;
                n_done = 1;
                m_done_st = 1;
            end else begin
                m_rel++;
            end
        end else if (m_done_st) begin
            m_done_st = 0;
        end else if (p_ready && v) begin
            if (per < PW'(MINP)) n_err = 1;
            else if (st == '0) n_done = 1;
            else begin
                m_on = 1; m_rel = 0; m_p = per; m_s = st; m_dir = d;
            end
        end
        p_done = n_done; p_abort = n_abort; p_err = n_err;
        p_ready = !m_on && !m_done_st;
        #1;
    endtask

    task automatic do_reset();
        bus.cmd_valid = 0; bus.abort = 0; bus.cmd_period = '0; bus.cmd_steps = '0; bus.cmd_dir = 0;
        reset_n = 1'b0;
        #1;
        check("reset_immediate", 64'({bus.cmd_ready, bus.busy, bus.done, bus.aborted, bus.err,
              bus.step_out, bus.dir_out, bus.steps_left}), 64'd0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check("reset_held", 64'({bus.cmd_ready, bus.busy, bus.done, bus.aborted, bus.err,
              bus.step_out, bus.dir_out, bus.steps_left}), 64'd0);
        reset_n = 1'b1;
        m_on = 0; m_done_st = 0; m_sl = '0; m_dir = 0;
        p_done = 0; p_abort = 0; p_err = 0; p_ready = 0;
        @(posedge clk_in);
        #1;
        p_ready = 1;
    endtask

    // period=4 steps=3 dir=1 timing relative to the accept edge.
    task automatic timing_run();
        int acc, done_c, rdy_c;
        int sq[$];
        logic dir1;
        done_c = -1; rdy_c = -1; dir1 = 0;
        cycle(1, 4, 3, 1, 0);
        acc = cyc;
        for (int k = 1; k <= 16; k++) begin
            cycle(0, 0, 0, 0, 0);
            if (k == 1) dir1 = o_dir;
            if (o_step) sq.push_back(cyc - acc);
            if (o_done && done_c < 0) done_c = cyc - acc;
            if (o_ready && rdy_c < 0) rdy_c = cyc - acc;
        end
        check("t_dir_at_N+1", 64'(dir1), 64'd1);
        check("t_num_steps", 64'(sq.size()), 64'd3);
        if (sq.size() == 3) begin
            check("t_step1", 64'(sq[0]), 64'd5);
            check("t_step2", 64'(sq[1]), 64'd9);
            check("t_step3", 64'(sq[2]), 64'd13);
        end
        check("t_done", 64'(done_c), 64'd14);
        check("t_ready", 64'(rdy_c), 64'd15);
    endtask

    typedef struct {
        int unsigned per;
        int unsigned st;
        bit          dir;
        int          abort_rel;
        int          n_steps;
        int          sl;
        bit          dn;
        bit          ab;
        bit          er;
        bit          fdir;
    } vec_t;

    vec_t vt[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int rises[$];
        logic prev_busy;

        //        per st dir abt  nst sl dn ab er fdir
        vt[0] = '{10, 5, 1, 23,  2, 3, 0, 1, 0, 1};
        vt[1] = '{ 1, 3, 0,  0,  0, 3, 0, 0, 1, 1};
        vt[2] = '{ 0, 0, 0,  0,  0, 3, 0, 0, 1, 1};
        vt[3] = '{ 5, 0, 0,  0,  0, 3, 1, 0, 0, 1};
        vt[4] = '{ 3, 2, 0,  7,  1, 1, 0, 1, 0, 0};
        vt[5] = '{ 2, 4, 1,  0,  4, 0, 1, 0, 0, 1};
        vt[6] = '{ 2, 1, 0,  1,  0, 1, 0, 1, 0, 0};
        vt[7] = '{ 7, 2, 1,  0,  2, 0, 1, 0, 0, 1};

        reset_n = 1'b1;
        bus.cmd_valid = 0; bus.abort = 0; bus.cmd_period = '0; bus.cmd_steps = '0; bus.cmd_dir = 0;
        @(posedge clk_in);
        #1;
        do_reset();

        timing_run();

        // Reset in the middle of a move, then the same command again.
        cycle(1, 4, 3, 1, 0);
        repeat (7) cycle(0, 0, 0, 0, 0);
        do_reset();
        timing_run();

        // Vector table.
        for (int i = 0; i < 8; i++) begin
            int ns;
            bit sd, sa, se, ended;
            ns = 0; sd = 0; sa = 0; se = 0; ended = 0;
            cycle(1, PW'(vt[i].per), CW'(vt[i].st), vt[i].dir, 0);
            for (int k = 1; k <= 300 && !ended; k++) begin
                cycle(0, 0, 0, 0, k == vt[i].abort_rel);
                ns += int'(o_step);
                sd |= o_done; sa |= o_aborted; se |= o_err;
                if (o_ready && !o_busy && !o_done && !o_err && !o_aborted) ended = 1;
            end
            check($sformatf("v%0d_ended", i), 64'(ended), 64'd1);
            check($sformatf("v%0d_steps", i), 64'(ns), 64'(vt[i].n_steps));
            check($sformatf("v%0d_left", i), 64'(o_sl), 64'(vt[i].sl));
            check($sformatf("v%0d_done", i), 64'(sd), 64'(vt[i].dn));
            check($sformatf("v%0d_aborted", i), 64'(sa), 64'(vt[i].ab));
            check($sformatf("v%0d_err", i), 64'(se), 64'(vt[i].er));
            check($sformatf("v%0d_dir", i), 64'(o_dir), 64'(vt[i].fdir));
        end

        // Back-to-back commands with cmd_valid held high.
        prev_busy = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1, 2, 2, 1, 0);
            if (o_busy && !prev_busy) rises.push_back(cyc);
            prev_busy = o_busy;
        end
        check("b2b_moves", 64'(rises.size()), 64'd3);
        if (rises.size() >= 3) begin
            check("b2b_gap1", 64'(rises[1] - rises[0]), 64'd7);
            check("b2b_gap2", 64'(rises[2] - rises[1]), 64'd7);
        end
        repeat (10) cycle(0, 0, 0, 0, 0);

        // Randomised traffic against the model, with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            cycle($urandom_range(0, 2) == 0, PW'($urandom_range(0, 6)), CW'($urandom_range(0, 4)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
